// File: rtl/forward_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight register writes for DEPTH stages,
// picks the youngest producer per source operand and stalls on producers not yet ready.
module forward_scoreboard #(
  parameter int unsigned NUM_REGISTERS_LOG2 = 5,
  parameter int unsigned NUM_READ_PORTS     = 2,
  parameter int unsigned DEPTH              = 3,
  parameter int unsigned LAT_W              = 3,
  localparam int unsigned SEL_W             = $clog2(DEPTH + 1)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         flush,
  input  logic                                         issue_valid,
  input  logic                                         issue_reg_write,
  input  logic [NUM_REGISTERS_LOG2-1:0]                issue_rd,
  input  logic [LAT_W-1:0]                             issue_latency,
  input  logic [NUM_READ_PORTS*NUM_REGISTERS_LOG2-1:0] rs_addr,
  output logic [NUM_READ_PORTS*SEL_W-1:0]              fwd_sel,
  output logic                                         stall,
  output logic [SEL_W-1:0]                             inflight,
  output logic                                         lat_err
);

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [NUM_REGISTERS_LOG2-1:0] rd_q  [DEPTH];
  logic [NUM_REGISTERS_LOG2-1:0] rd_d  [DEPTH];
  logic [LAT_W-1:0]              cnt_q [DEPTH];
  logic [LAT_W-1:0]              cnt_d [DEPTH];
  logic [SEL_W-1:0]              inflight_q, inflight_d;
  logic                          lat_err_q, lat_err_d;

  logic                          load;
  logic                          lat_over;
  logic [LAT_W-1:0]              lat_eff;

  // Lowest matching slot wins, so a younger busy producer is never bypassed
  // by an older ready one.
  always_comb begin
    logic [NUM_REGISTERS_LOG2-1:0] rs;
    logic                          found;
    stall   = 1'b0;
    fwd_sel = '0;
    for (int unsigned p = 0; p < NUM_READ_PORTS; p++) begin
      rs    = rs_addr[p*NUM_REGISTERS_LOG2 +: NUM_REGISTERS_LOG2];
      found = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found && valid_q[k] && (rd_q[k] == rs) && (rs != '0)) begin
          found                    = 1'b1;
          fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
          if (cnt_q[k] != '0) stall = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load     = issue_valid && !stall && issue_reg_write && (issue_rd != '0);
    lat_over = (32'(issue_latency) >= DEPTH);
    lat_eff  = lat_over ? LAT_W'(DEPTH - 1) : issue_latency;

    valid_d[0] = load;
    rd_d[0]    = issue_rd;
    cnt_d[0]   = lat_eff;
    for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
      valid_d[k+1] = valid_q[k];
      rd_d[k+1]    = rd_q[k];
      cnt_d[k+1]   = (cnt_q[k] != '0) ? cnt_q[k] - LAT_W'(1) : '0;
    end

    lat_err_d = lat_err_q | (load && lat_over);

    inflight_d = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      inflight_d = inflight_d + SEL_W'(valid_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    cnt_q <= cnt_d;
    if (reset) begin
      valid_q    <= '0;
      inflight_q <= '0;
      lat_err_q  <= 1'b0;
    end else if (flush) begin
      valid_q    <= '0;
      inflight_q <= '0;
    end else begin
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      lat_err_q  <= lat_err_d;
    end
  end

  assign inflight = inflight_q;
  assign lat_err  = lat_err_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard (DEPTH=3, two read ports).
module tb_forward_scoreboard;

  localparam int unsigned RW    = 5;
  localparam int unsigned NP    = 2;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned LW    = 3;
  localparam int unsigned SW    = 2;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic             issue_valid, issue_reg_write;
  logic [RW-1:0]    issue_rd;
  logic [LW-1:0]    issue_latency;
  logic [NP*RW-1:0] rs_addr;
  logic [NP*SW-1:0] fwd_sel;
  logic             stall;
  logic [SW-1:0]    inflight;
  logic             lat_err;

  int tests_run = 0;
  int tests_failed = 0;

  forward_scoreboard #(
    .NUM_REGISTERS_LOG2(RW),
    .NUM_READ_PORTS    (NP),
    .DEPTH             (DEPTH),
    .LAT_W             (LW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_reg_write(issue_reg_write),
    .issue_rd       (issue_rd),
    .issue_latency  (issue_latency),
    .rs_addr        (rs_addr),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .inflight       (inflight),
    .lat_err        (lat_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic wr, input int rd, input int lat);
    issue_valid     = v;
    issue_reg_write = wr;
    issue_rd        = RW'(rd);
    issue_latency   = LW'(lat);
  endtask

  task automatic set_rs(input int r0, input int r1);
    rs_addr = {RW'(r1), RW'(r0)};
    #1;
  endtask

  function automatic int sel(input int p);
    logic [NP*SW-1:0] f;
    f = fwd_sel;
    return int'(f[p*SW +: SW]);
  endfunction

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_issue(0, 0, 0, 0);
    set_rs(5, 5);

    // reset
    tick(); tick();
    check("rst_sel0", sel(0), 0);
    check("rst_sel1", sel(1), 0);
    check("rst_stall", int'(stall), 0);
    check("rst_inflight", int'(inflight), 0);
    check("rst_laterr", int'(lat_err), 0);
    reset = 1'b0;

    // single producer walks through the slots
    set_rs(5, 0);
    set_issue(1, 1, 5, 0);
    tick();
    set_issue(0, 0, 0, 0);
    #1;
    check("walk_sel_s0", sel(0), 1);
    check("walk_inf_s0", int'(inflight), 1);
    check("walk_stall", int'(stall), 0);
    tick();
    check("walk_sel_s1", sel(0), 2);
    check("walk_inf_s1", int'(inflight), 1);
    tick();
    check("walk_sel_s2", sel(0), 3);
    check("walk_inf_s2", int'(inflight), 1);
    tick();
    check("walk_sel_gone", sel(0), 0);
    check("walk_inf_gone", int'(inflight), 0);

    // youngest producer wins
    set_rs(0, 0);
    set_issue(1, 1, 7, 0);
    tick();
    tick();
    set_issue(0, 0, 0, 0);
    set_rs(0, 7);
    check("young_sel1", sel(1), 1);
    check("young_inf", int'(inflight), 2);
    tick(); tick(); tick();
    check("young_drain", int'(inflight), 0);

    // load-use stall, stalled issue dropped
    set_rs(0, 0);
    set_issue(1, 1, 3, 1);
    tick();
    set_rs(0, 3);
    check("lu_stall", int'(stall), 1);
    check("lu_sel1", sel(1), 1);
    tick();
    set_issue(0, 0, 0, 0);
    #1;
    check("lu_stall_clr", int'(stall), 0);
    check("lu_sel1_after", sel(1), 2);
    check("lu_drop_inf", int'(inflight), 1);
    tick(); tick();
    check("lu_drain", int'(inflight), 0);

    // bubbles: rd=0 and no write
    set_rs(0, 0);
    set_issue(1, 1, 0, 0);
    tick();
    set_issue(1, 0, 9, 0);
    tick();
    set_issue(0, 0, 0, 0);
    set_rs(0, 9);
    check("bub_sel0", sel(0), 0);
    check("bub_sel1", sel(1), 0);
    check("bub_inf", int'(inflight), 0);

    // latency clamp: lat=5 behaves as 2
    set_rs(0, 0);
    set_issue(1, 1, 4, 5);
    tick();
    set_issue(0, 0, 0, 0);
    set_rs(4, 0);
    check("clamp_laterr", int'(lat_err), 1);
    check("clamp_stall0", int'(stall), 1);
    check("clamp_sel0", sel(0), 1);
    tick();
    check("clamp_stall1", int'(stall), 1);
    check("clamp_sel1", sel(0), 2);
    tick();
    check("clamp_stall2", int'(stall), 0);
    check("clamp_sel2", sel(0), 3);
    tick();
    check("clamp_gone", sel(0), 0);

    // flush during stall
    set_rs(0, 0);
    set_issue(1, 1, 4, 5);
    tick();
    set_issue(1, 1, 8, 0);
    set_rs(4, 0);
    check("fl_stall_pre", int'(stall), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_issue(0, 0, 0, 0);
    #1;
    check("fl_stall", int'(stall), 0);
    check("fl_inf", int'(inflight), 0);
    check("fl_sel0", sel(0), 0);
    check("fl_laterr", int'(lat_err), 1);

    // only reset clears lat_err
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_laterr_clr", int'(lat_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
